// File: rtl/dataframe_merger_pkg.sv
// Shared constants and state encoding for the data-frame merger.
// Stream width and default frame limit match the data-frame generators.
package dataframe_merger_pkg;

  localparam int unsigned RFDC_TDATA_WIDTH        = 64;
  localparam int unsigned RFDC_TKEEP_WIDTH        = RFDC_TDATA_WIDTH / 8;
  localparam int unsigned DEFAULT_MAX_FRAME_LINES = 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DROP   = 2'd2
  } merger_state_t;

endpackage

// File: rtl/dataframe_merger_rr_arbiter.sv
// Combinational rotating-priority encoder: first requester at or above
// rr_ptr, wrapping upward through the channel range.
module rr_arbiter
  import dataframe_merger_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  localparam int unsigned CH_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   rr_ptr,
  output logic [CH_W-1:0]   grant,
  output logic              any_req
);

  logic [2*NUM_CH-1:0] req2;
  logic [NUM_CH-1:0]   rot;
  logic [CH_W:0]       sum;

  // Doubling the request vector turns the wrap-around search into a plain
  // lowest-bit search on the rotated copy.
  always_comb begin
    req2    = {req, req};
    rot     = NUM_CH'(req2 >> rr_ptr);
    any_req = 1'b0;
    sum     = '0;
    grant   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!any_req && rot[i]) begin
        any_req = 1'b1;
        sum     = {1'b0, rr_ptr} + (CH_W+1)'(i);
      end
    end
    if (sum >= (CH_W+1)'(NUM_CH)) begin
      sum = sum - (CH_W+1)'(NUM_CH);
    end
    grant = sum[CH_W-1:0];
  end

endmodule

// File: rtl/dataframe_merger.sv
// Frame-atomic round-robin merger of NUM_CH AXI4-Stream frame sources into
// one registered AXI4-Stream output, truncating over-length frames.
module dataframe_merger
  import dataframe_merger_pkg::*;
#(
  parameter int unsigned NUM_CH          = 8,
  parameter int unsigned MAX_FRAME_LINES = DEFAULT_MAX_FRAME_LINES,
  parameter int unsigned FRAME_CNT_WIDTH = 32
) (
  input  logic                                 ACLK,
  input  logic                                 ARESET,
  input  logic                                 SET_CONFIG,
  input  logic [NUM_CH*RFDC_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [NUM_CH*RFDC_TKEEP_WIDTH-1:0]   S_AXIS_TKEEP,
  input  logic [NUM_CH-1:0]                    S_AXIS_TLAST,
  input  logic [NUM_CH-1:0]                    S_AXIS_TVALID,
  output logic [NUM_CH-1:0]                    S_AXIS_TREADY,
  output logic [RFDC_TDATA_WIDTH-1:0]          M_AXIS_TDATA,
  output logic [RFDC_TKEEP_WIDTH-1:0]          M_AXIS_TKEEP,
  output logic                                 M_AXIS_TLAST,
  output logic                                 M_AXIS_TVALID,
  input  logic                                 M_AXIS_TREADY,
  output logic [$clog2(NUM_CH)-1:0]            CUR_CHANNEL,
  output logic [FRAME_CNT_WIDTH-1:0]           FRAME_COUNT,
  output logic                                 MERGER_ERROR
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned W     = RFDC_TDATA_WIDTH;
  localparam int unsigned KW    = RFDC_TKEEP_WIDTH;
  localparam int unsigned CNT_W = $clog2(MAX_FRAME_LINES + 1);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_FRAME_LINES - 1);
  localparam logic [CH_W-1:0]  TOP_CH   = CH_W'(NUM_CH - 1);

  merger_state_t state, state_next;

  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  cur_ch;
  logic [CH_W-1:0]  grant_idx;
  logic [CH_W-1:0]  next_ch;
  logic             any_req;
  logic [CNT_W-1:0] beat_cnt;

  logic             out_free;
  logic             sel_ready;
  logic             sel_valid;
  logic             sel_last;
  logic [W-1:0]     sel_data;
  logic [KW-1:0]    sel_keep;
  logic             s_hs;
  logic             load_out;
  logic             at_limit;
  logic             frame_end;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req     (S_AXIS_TVALID),
    .rr_ptr  (rr_ptr),
    .grant   (grant_idx),
    .any_req (any_req)
  );

  assign out_free  = !M_AXIS_TVALID || M_AXIS_TREADY;
  assign sel_ready = ((state == STREAM) && out_free) || (state == DROP);
  assign s_hs      = sel_valid && sel_ready;
  assign load_out  = (state == STREAM) && s_hs;
  assign at_limit  = (beat_cnt == LAST_IDX);
  assign frame_end = load_out && (sel_last || at_limit);
  assign next_ch   = (cur_ch == TOP_CH) ? '0 : cur_ch + 1'b1;

  // Channel select written as an unrolled compare so every slice is constant.
  always_comb begin
    sel_valid     = 1'b0;
    sel_last      = 1'b0;
    sel_data      = '0;
    sel_keep      = '0;
    S_AXIS_TREADY = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (cur_ch == CH_W'(c)) begin
        sel_valid        = S_AXIS_TVALID[c];
        sel_last         = S_AXIS_TLAST[c];
        sel_data         = S_AXIS_TDATA[c*W +: W];
        sel_keep         = S_AXIS_TKEEP[c*KW +: KW];
        S_AXIS_TREADY[c] = sel_ready;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (any_req) state_next = STREAM;
      end
      STREAM: begin
        if (s_hs) begin
          if (sel_last)      state_next = IDLE;
          else if (at_limit) state_next = DROP;
        end
      end
      DROP: begin
        if (s_hs && sel_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state <= IDLE;
    end else if (SET_CONFIG) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rr_ptr       <= '0;
      cur_ch       <= '0;
      beat_cnt     <= '0;
      FRAME_COUNT  <= '0;
      MERGER_ERROR <= 1'b0;
    end else if (SET_CONFIG) begin
      rr_ptr       <= '0;
      cur_ch       <= '0;
      beat_cnt     <= '0;
      FRAME_COUNT  <= '0;
      MERGER_ERROR <= 1'b0;
    end else begin
      if (state == IDLE && any_req) begin
        cur_ch   <= grant_idx;
        beat_cnt <= '0;
      end
      if (load_out) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (frame_end) begin
        FRAME_COUNT <= FRAME_COUNT + 1'b1;
      end
      if (load_out && !sel_last && at_limit) begin
        MERGER_ERROR <= 1'b1;
      end
      if (s_hs && sel_last) begin
        rr_ptr <= next_ch;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      M_AXIS_TDATA  <= '0;
      M_AXIS_TKEEP  <= '0;
      M_AXIS_TLAST  <= 1'b0;
      M_AXIS_TVALID <= 1'b0;
    end else if (SET_CONFIG) begin
      M_AXIS_TDATA  <= '0;
      M_AXIS_TKEEP  <= '0;
      M_AXIS_TLAST  <= 1'b0;
      M_AXIS_TVALID <= 1'b0;
    end else if (load_out) begin
      M_AXIS_TDATA  <= sel_data;
      M_AXIS_TKEEP  <= sel_keep;
      M_AXIS_TLAST  <= sel_last || at_limit;
      M_AXIS_TVALID <= 1'b1;
    end else if (M_AXIS_TREADY) begin
      M_AXIS_TVALID <= 1'b0;
    end
  end

  assign CUR_CHANNEL = cur_ch;

endmodule

// File: doc/dataframe_merger.md
Name: dataframe_merger

Overview:
- Frame-atomic round-robin merger for the per-channel data-frame streams produced by the per-channel data-frame generators.
- Takes NUM_CH AXI4-Stream frame inputs and emits one merged AXI4-Stream toward the DMA/packetizer.
- Never interleaves beats of two frames.
- Truncates frames that exceed MAX_FRAME_LINES and flags the error.

Parameters:
- NUM_CH, 8, number of input channels (2..16).
- MAX_FRAME_LINES, 1024, maximum beats per frame, header and footer included.
- FRAME_CNT_WIDTH, 32, width of the merged-frame counter.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  asynchronous, active-high reset.
- SET_CONFIG  in  1  synchronous flush; same effect as reset, applied on the clock edge.
- S_AXIS_TDATA  in  NUM_CH*`RFDC_TDATA_WIDTH  per-channel data; channel i occupies slice i.
- S_AXIS_TKEEP  in  NUM_CH*`RFDC_TDATA_WIDTH/8  per-channel keep.
- S_AXIS_TLAST  in  NUM_CH  per-channel last.
- S_AXIS_TVALID  in  NUM_CH  per-channel valid.
- S_AXIS_TREADY  out  NUM_CH  per-channel ready.
- M_AXIS_TDATA  out  `RFDC_TDATA_WIDTH  merged data (registered).
- M_AXIS_TKEEP  out  `RFDC_TDATA_WIDTH/8  merged keep.
- M_AXIS_TLAST  out  1  merged last.
- M_AXIS_TVALID  out  1  merged valid.
- M_AXIS_TREADY  in  1  downstream ready.
- CUR_CHANNEL  out  $clog2(NUM_CH)  channel currently granted.
- FRAME_COUNT  out  FRAME_CNT_WIDTH  frames emitted on M_AXIS; wraps modulo 2^FRAME_CNT_WIDTH.
- MERGER_ERROR  out  1  sticky: at least one frame was truncated.

Behaviour:
- Reset and flush values:
  - ARESET (async) and SET_CONFIG (sync) clear: state=IDLE, rr_ptr=0, all S_AXIS_TREADY=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0.
  - TDATA=0, TKEEP=0, CUR_CHANNEL=0, FRAME_COUNT=0, MERGER_ERROR=0.
  - If reset or flush arrives mid-frame, the partial frame is abandoned with no TLAST emitted. Upstream is flushed by the same SET_CONFIG.
- State machine, states IDLE / STREAM / DROP:
  - IDLE: search TVALID starting at rr_ptr, wrapping upward. The first asserted channel g is latched into CUR_CHANNEL, beat_cnt=0, and the next state is STREAM. No TREADY is asserted in IDLE.
  - STREAM: S_AXIS_TREADY[g] = !M_AXIS_TVALID || M_AXIS_TREADY. All other channels' TREADY=0.
  - An accepted beat loads the output register on the same edge. beat_cnt increments on each accepted beat.
  - Accepted beat with TLAST=1: next state IDLE, rr_ptr = (g+1) mod NUM_CH, FRAME_COUNT increments.
  - Accepted beat with TLAST=0 and beat_cnt == MAX_FRAME_LINES-1: the output beat has M_AXIS_TLAST forced to 1, MERGER_ERROR is set, FRAME_COUNT increments, next state DROP.
  - DROP: S_AXIS_TREADY[g]=1 and beats are discarded; the output register is not loaded. On the accepted TLAST beat: next state IDLE, rr_ptr = (g+1) mod NUM_CH.
- Output register:
  - Holds its contents while M_AXIS_TVALID && !M_AXIS_TREADY, per AXIS rules.
  - M_AXIS_TVALID clears when a beat is consumed and no new beat is loaded.
- Latency:
  - Input valid in IDLE, to grant: 1 cycle. First beat accepted in the grant cycle; on M_AXIS one cycle later. First-beat latency is 2 cycles.
  - Steady-state throughput is 1 beat/cycle within a frame.
  - There is exactly one bubble cycle (IDLE) between consecutive frames.
- Fairness and boundary cases:
  - A channel whose TVALID drops mid-frame keeps the grant, with no timeout.
  - Simultaneous requests are ordered by rr_ptr, so each requester is served within NUM_CH frames.
  - rr_ptr wraps from NUM_CH-1 to 0.
  - A 1-beat frame (TLAST on the first beat) is legal.
  - MERGER_ERROR is cleared only by ARESET or SET_CONFIG.
- Data passes through unmodified; only TLAST can be forced.

Decomposition:
- `RFDC_TDATA_WIDTH and the frame-line constants come from dataframe_config.vh.
- Add to the same shared header:
  - the merger state encoding (IDLE=2'd0, STREAM=2'd1, DROP=2'd2);
  - the default MAX_FRAME_LINES.
- One natural sub-module: rr_arbiter, a combinational rotating-priority encoder. Inputs: request vector and rr_ptr. Outputs: grant index and any_req.

Test Plan:
- Single frame, one channel: ch3 sends a 4-beat frame with M_AXIS_TREADY=1 -> 4 beats on M, TLAST on beat 4, first beat 2 cycles after TVALID, CUR_CHANNEL=3, FRAME_COUNT=1.
- Round robin: ch0, ch1 and ch5 each hold a 3-beat frame from cycle 0 -> output order is ch0, ch1, ch5, with one idle cycle between frames. A second frame from ch0 then queues behind ch1 and ch5.
- Backpressure: M_AXIS_TREADY toggles 1,0,0,1,... during an 8-beat frame -> no beat lost or duplicated, and TDATA stays stable while TVALID && !TREADY.
- Overlength: with MAX_FRAME_LINES=4, ch2 sends 7 beats (TLAST on beat 7) -> M carries 4 beats with TLAST on beat 4, beats 5-7 are consumed but not forwarded, MERGER_ERROR=1, FRAME_COUNT=1. The next frame from ch2 passes normally.
- Stall mid-frame: ch1 drops TVALID for 5 cycles while ch4 is valid -> ch4 is not granted until ch1's TLAST is accepted.
- Reset mid-frame: ARESET asserted asynchronously at beat 2 of 6 -> M_AXIS_TVALID and TREADY go 0 immediately and all counters and flags read 0. After release, a new frame is arbitrated from rr_ptr=0.
